// File: rtl/pipelined_addsub_pkg.sv
// Shared constants for the pipelined adder/subtractor: mode encodings,
// default geometry and a helper that validates a (WIDTH, STAGES) pair.
package pipelined_addsub_pkg;

  // Mode encodings for in_sub.
  localparam logic ADDSUB_ADD = 1'b0;
  localparam logic ADDSUB_SUB = 1'b1;

  // Default geometry: 32-bit operands over four 8-bit chunks.
  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  // A geometry is legal when every stage gets the same non-empty chunk.
  function automatic logic addsub_cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational C-bit ripple adder built from 1-bit full-adder cells.
// cmsb is the carry into the chunk MSB so the caller can derive signed
// overflow when this chunk holds the operand MSB.
module addsub_chunk #(
  parameter int C = 8
) (
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  input  logic         cin,
  output logic [C-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  logic carry;

  // Ripple the carry through one full-adder cell per bit, LSB first.
  always_comb begin
    carry = cin;
    sum   = '0;
    cmsb  = 1'b0;
    cout  = 1'b0;
    for (int i = 0; i < C; i++) begin
      if (i == C - 1) cmsb = carry;
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor with a valid/ready stream on
// both sides. Stage k adds operand chunk k using the registered carry of
// stage k-1. Operand chunks not yet consumed travel skewed alongside the
// beat; finished low-order sum chunks accumulate deskewed behind it.
//
// Handshake: a beat transfers on a rising edge when valid and ready are
// both high on that side. The whole pipe advances together
// (adv = !out_valid | out_ready); in_ready equals adv combinationally,
// so a stalled output freezes every stage bit-exact and blocks input.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int C = WIDTH / STAGES;

  if (!addsub_cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of STAGES");
  end

  logic adv;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be added, including this stage's chunk.
    localparam int REM = WIDTH - k * C;

    logic [REM-1:0]       x_in;
    logic [REM-1:0]       y_in;
    logic                 c_in;
    logic                 v_in;
    logic [C-1:0]         ch_sum;
    logic                 ch_cout;
    logic                 ch_cmsb;
    logic [(k+1)*C-1:0]   sum_d;
    logic [(k+1)*C-1:0]   sum_q;
    logic                 v_q;
    logic                 c_q;

    if (k == 0) begin : g_src
      // Two's-complement subtract: invert Y and force the first carry-in.
      assign x_in  = in_x;
      assign y_in  = (in_sub == ADDSUB_SUB) ? ~in_y : in_y;
      assign c_in  = (in_sub == ADDSUB_SUB) ? 1'b1 : in_cin;
      assign v_in  = in_valid;
      assign sum_d = ch_sum;
    end else begin : g_src
      assign x_in  = g_stage[k-1].g_fwd.x_q;
      assign y_in  = g_stage[k-1].g_fwd.y_q;
      assign c_in  = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
      assign sum_d = {ch_sum, g_stage[k-1].sum_q};
    end

    addsub_chunk #(.C(C)) u_chunk (
      .a    (x_in[C-1:0]),
      .b    (y_in[C-1:0]),
      .cin  (c_in),
      .sum  (ch_sum),
      .cout (ch_cout),
      .cmsb (ch_cmsb)
    );

    // Stage valid, chunk carry and the deskewed partial sum.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        v_q   <= v_in;
        c_q   <= ch_cout;
        sum_q <= sum_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [REM-C-1:0] x_q;
      logic [REM-C-1:0] y_q;

      // Skewed operand chunks waiting for later stages.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          x_q <= '0;
          y_q <= '0;
        end else if (adv) begin
          x_q <= x_in[REM-1:C];
          y_q <= y_in[REM-1:C];
        end
      end
    end else begin : g_last
      logic ovf_q;

      // Signed overflow: carry into the MSB differs from carry out of it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ch_cmsb ^ ch_cout;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign out_sum   = g_stage[STAGES-1].sum_q;
  assign out_cout  = g_stage[STAGES-1].c_q;
  assign out_ovf   = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed vectors on a 32x4 instance plus a
// randomised handshake sweep over four geometries against an X+/-Y model.
module tb_pipelined_addsub;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic rst_sw;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_miss;

  // ---------------- directed DUT (32 bits, 4 stages) ----------------
  logic        in_valid, in_ready, in_sub, in_cin;
  logic [31:0] in_x, in_y;
  logic        out_valid, out_ready, out_cout, out_ovf;
  logic [31:0] out_sum;

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  // ---------------- random sweep over geometries ----------------
  localparam int N_RAND = 1000;
  bit sweep_go;
  bit sw_done [4];

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int W = (g == 0) ? 32 : (g == 1) ? 32 : (g == 2) ? 8 : 64;
    localparam int S = (g == 0) ? 4  : (g == 1) ? 1  : (g == 2) ? 8 : 2;

    logic         iv, ir, sub, cin, ov, ordy, co, of;
    logic [W-1:0] x, y, sum;
    logic [W+1:0] exp_q[$];

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk       (clk),
      .rst       (rst_sw),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_sub    (sub),
      .in_cin    (cin),
      .in_x      (x),
      .in_y      (y),
      .out_valid (ov),
      .out_ready (ordy),
      .out_sum   (sum),
      .out_cout  (co),
      .out_ovf   (of)
    );

    initial begin
      logic [63:0]  r;
      logic [W-1:0] ye;
      logic [W:0]   full;
      logic [W:0]   cinx;
      logic         ovf;
      logic [W+1:0] e;
      int           acc;
      int           cyc;
      iv = 1'b0; ordy = 1'b0; sub = 1'b0; cin = 1'b0; x = '0; y = '0;
      acc = 0; cyc = 0;
      wait (sweep_go);
      while ((acc < N_RAND || exp_q.size() != 0) && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        iv   = (acc < N_RAND) && ($urandom_range(0, 3) != 0);
        ordy = (acc >= N_RAND) || ($urandom_range(0, 3) != 0);
        sub  = 1'($urandom_range(0, 1));
        cin  = 1'($urandom_range(0, 1));
        r = {$urandom, $urandom};
        x = r[W-1:0];
        r = {$urandom, $urandom};
        y = r[W-1:0];
        #1;
        if (ov && ordy) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL sweep_extra W=%0d S=%0d: got result %h, required none", W, S, sum);
          end else begin
            e = exp_q.pop_front();
            if ({co, of, sum} !== e) begin
              n_miss++;
              $display("FAIL sweep W=%0d S=%0d: got {cout,ovf,sum}=%h required %h", W, S, {co, of, sum}, e);
            end
          end
        end
        if (iv && ir) begin
          ye   = sub ? ~y : y;
          cinx = '0;
          cinx[0] = sub ? 1'b1 : cin;
          full = {1'b0, x} + {1'b0, ye} + cinx;
          ovf  = (x[W-1] == ye[W-1]) && (full[W-1] != x[W-1]);
          exp_q.push_back({full[W], ovf, full[W-1:0]});
          acc++;
        end
      end
      iv = 1'b0;
      if (cyc >= 20000) begin
        n_vec++;
        n_miss++;
        $display("FAIL sweep_timeout W=%0d S=%0d: accepted %0d, pending %0d", W, S, acc, exp_q.size());
      end
      sw_done[g] = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drain;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Present one beat with out_ready high and report edges-to-result.
  task automatic apply_one(input logic sub, input logic cin,
                           input logic [31:0] x, input logic [31:0] y,
                           output int lat, output logic [31:0] s,
                           output logic co, output logic of);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sub    = sub;
    in_cin    = cin;
    in_x      = x;
    in_y      = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    s  = out_sum;
    co = out_cout;
    of = out_ovf;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_vec++; if (out_sum !== 32'h0) begin n_miss++; $display("FAIL reset_out_sum: got %h required 0", out_sum); end
    n_vec++; if (out_cout !== 1'b0) begin n_miss++; $display("FAIL reset_out_cout: got %b required 0", out_cout); end
    n_vec++; if (out_ovf !== 1'b0) begin n_miss++; $display("FAIL reset_out_ovf: got %b required 0", out_ovf); end
    n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_wrap;
    int lat; logic [31:0] s; logic co, of;
    apply_one(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, lat, s, co, of);
    n_vec++; if (lat !== 4) begin n_miss++; $display("FAIL add_wrap_latency: got %0d required 4", lat); end
    n_vec++; if (s !== 32'h0000_0000) begin n_miss++; $display("FAIL add_wrap_sum: got %h required 00000000", s); end
    n_vec++; if (co !== 1'b1) begin n_miss++; $display("FAIL add_wrap_cout: got %b required 1", co); end
    n_vec++; if (of !== 1'b0) begin n_miss++; $display("FAIL add_wrap_ovf: got %b required 0", of); end
  endtask

  task automatic test_sub;
    int lat; logic [31:0] s; logic co, of;
    apply_one(1'b1, 1'b0, 32'h0000_0005, 32'h0000_0007, lat, s, co, of);
    n_vec++; if ({co, of, s} !== {1'b0, 1'b0, 32'hFFFF_FFFE}) begin n_miss++; $display("FAIL sub_borrow: got c=%b o=%b s=%h required c=0 o=0 s=fffffffe", co, of, s); end
    apply_one(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, lat, s, co, of);
    n_vec++; if ({co, of, s} !== {1'b1, 1'b1, 32'h7FFF_FFFF}) begin n_miss++; $display("FAIL sub_ovf: got c=%b o=%b s=%h required c=1 o=1 s=7fffffff", co, of, s); end
    // Carry-in must be ignored in subtract mode.
    apply_one(1'b1, 1'b1, 32'h0000_0007, 32'h0000_0005, lat, s, co, of);
    n_vec++; if ({co, of, s} !== {1'b1, 1'b0, 32'h0000_0002}) begin n_miss++; $display("FAIL sub_cin_ignored: got c=%b o=%b s=%h required c=1 o=0 s=00000002", co, of, s); end
  endtask

  task automatic test_add_ovf;
    int lat; logic [31:0] s; logic co, of;
    apply_one(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, lat, s, co, of);
    n_vec++; if ({co, of, s} !== {1'b0, 1'b1, 32'h8000_0000}) begin n_miss++; $display("FAIL add_ovf: got c=%b o=%b s=%h required c=0 o=1 s=80000000", co, of, s); end
    apply_one(1'b0, 1'b1, 32'h0000_FFFF, 32'h0000_0001, lat, s, co, of);
    n_vec++; if ({co, of, s} !== {1'b0, 1'b0, 32'h0001_0001}) begin n_miss++; $display("FAIL add_chunk_carry: got c=%b o=%b s=%h required c=0 o=0 s=00010001", co, of, s); end
  endtask

  // Eight beats, consumer stalls for cycles 7..9; beat i = {i,28'h1} + 0x0FFFFFFF.
  task automatic test_back_to_back;
    logic [33:0] exp_q[$];
    logic [33:0] e;
    int sent, got, cyc, last_ret;
    drain();
    sent = 0; got = 0; cyc = 0; last_ret = 0;
    while (got < 8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      out_ready = !(cyc >= 7 && cyc <= 9);
      if (sent < 8) begin
        in_valid = 1'b1;
        in_sub   = 1'b0;
        in_cin   = 1'b0;
        in_x     = {sent[3:0], 28'h000_0001};
        in_y     = 32'h0FFF_FFFF;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL stall_in_ready: got %b required 0 at cycle %0d", in_ready, cyc); end
        if (exp_q.size() != 0) begin
          n_vec++; if ({out_cout, out_ovf, out_sum} !== exp_q[0]) begin n_miss++; $display("FAIL stall_hold: got %h required %h at cycle %0d", {out_cout, out_ovf, out_sum}, exp_q[0], cyc); end
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++; $display("FAIL b2b_extra: got result %h, required none", out_sum);
        end else begin
          e = exp_q.pop_front();
          if ({out_cout, out_ovf, out_sum} !== e) begin n_miss++; $display("FAIL b2b_result: got %h required %h", {out_cout, out_ovf, out_sum}, e); end
        end
        got++;
        last_ret = cyc;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, (sent == 7), sent[3:0] + 4'd1, 28'h000_0000});
        sent++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_vec++; if (got !== 8) begin n_miss++; $display("FAIL b2b_count: got %0d results required 8", got); end
    n_vec++; if (last_ret !== 15) begin n_miss++; $display("FAIL b2b_cycles: got last result at %0d required 15", last_ret); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] s; logic co, of;
    drain();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sub   = 1'b0;
      in_cin   = 1'b0;
      in_x     = 32'(i);
      in_y     = 32'h0000_0001;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b1) begin n_miss++; $display("FAIL mid_pre_valid: got %b required 1", out_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL mid_async_drop: got %b required 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL mid_in_ready: got %b required 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    apply_one(1'b0, 1'b0, 32'h1234_5678, 32'h1111_1111, lat, s, co, of);
    n_vec++; if (lat !== 4) begin n_miss++; $display("FAIL mid_latency: got %0d required 4", lat); end
    n_vec++; if ({co, of, s} !== {1'b0, 1'b0, 32'h2345_6789}) begin n_miss++; $display("FAIL mid_first_result: got c=%b o=%b s=%h required c=0 o=0 s=23456789", co, of, s); end
  endtask

  task automatic test_sweep;
    int cyc;
    cyc = 0;
    @(negedge clk);
    rst_sw   = 1'b0;
    sweep_go = 1'b1;
    while (!(sw_done[0] && sw_done[1] && sw_done[2] && sw_done[3]) && cyc < 30000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 30000) begin
      n_vec++; n_miss++;
      $display("FAIL sweep_wait: sweep did not complete within %0d cycles", cyc);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec = 0; n_miss = 0;
    rst = 1'b1; rst_sw = 1'b1; sweep_go = 1'b0;
    in_valid = 1'b0; in_sub = 1'b0; in_cin = 1'b0;
    in_x = '0; in_y = '0; out_ready = 1'b0;
    test_reset();
    test_add_wrap();
    test_sub();
    test_add_ovf();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
